// File: rtl/pdm_multi_channel.sv
// Multi-channel first-order pulse-density modulator.
// Each channel accumulates its level modulo 2^WIDTH. The carry-out of that sum is the PDM bit.
// Level writes either apply at once or wait in a shadow register until the frame boundary.
module pdm_multi_channel #(
   parameter int unsigned WIDTH    = 5,
   parameter int unsigned CHANNELS = 4,
   localparam int unsigned CB      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                write_en,
   input  logic [CB-1:0]       wr_chan,
   input  logic [WIDTH-1:0]    wr_data,
   input  logic                sync_mode,
   output logic [CHANNELS-1:0] pdm_out,
   output logic [CHANNELS-1:0] pending,
   output logic                frame_start
);

   logic [WIDTH-1:0]    level_q  [CHANNELS];
   logic [WIDTH-1:0]    level_d  [CHANNELS];
   logic [WIDTH-1:0]    shadow_q [CHANNELS];
   logic [WIDTH-1:0]    shadow_d [CHANNELS];
   logic [WIDTH-1:0]    acc_q    [CHANNELS];
   logic [WIDTH-1:0]    acc_d    [CHANNELS];
   logic [CHANNELS-1:0] pdm_q, pdm_d;
   logic [CHANNELS-1:0] pend_q, pend_d;
   logic [WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
   logic                boundary;
   logic                wr_valid;

   // Next-state for the accumulators, levels, shadows and frame counter.
   always_comb begin
      logic [WIDTH:0] sum;
      sum         = '0;
      boundary    = (frame_cnt_q == {WIDTH{1'b1}});
      // Out-of-range channel numbers are dropped without touching any state.
      wr_valid    = write_en && (32'(wr_chan) < CHANNELS);
      frame_cnt_d = frame_cnt_q + 1'b1;
      pdm_d       = '0;
      pend_d      = pend_q;
      for (int c = 0; c < CHANNELS; c++) begin
         sum         = {1'b0, acc_q[c]} + {1'b0, level_q[c]};
         acc_d[c]    = sum[WIDTH-1:0];
         pdm_d[c]    = sum[WIDTH];
         level_d[c]  = level_q[c];
         shadow_d[c] = shadow_q[c];
         if (boundary && pend_q[c]) begin
            level_d[c] = shadow_q[c];
            pend_d[c]  = 1'b0;
         end
         // A write to this channel overrides any shadow applied on the same edge.
         if (wr_valid && (wr_chan == CB'(c))) begin
            if (!sync_mode || boundary) begin
               level_d[c] = wr_data;
               pend_d[c]  = 1'b0;
            end else begin
               shadow_d[c] = wr_data;
               pend_d[c]   = 1'b1;
            end
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q <= '0;
         pdm_q       <= '0;
         pend_q      <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            level_q[c]  <= '0;
            shadow_q[c] <= '0;
            acc_q[c]    <= '0;
         end
      end else begin
         frame_cnt_q <= frame_cnt_d;
         pdm_q       <= pdm_d;
         pend_q      <= pend_d;
         for (int c = 0; c < CHANNELS; c++) begin
            level_q[c]  <= level_d[c];
            shadow_q[c] <= shadow_d[c];
            acc_q[c]    <= acc_d[c];
         end
      end
   end

   // Outputs are straight register taps plus the frame-start decode.
   always_comb begin
      pdm_out     = pdm_q;
      pending     = pend_q;
      frame_start = (frame_cnt_q == '0);
   end

endmodule

// File: tb/tb_pdm_multi_channel.sv
// Self-checking bench: a 4-channel and a 3-channel instance share the same stimulus.
// A behavioural model pushes expected outputs after each edge; they are compared at the next negedge.
module tb_pdm_multi_channel;

   logic       clk = 1'b0;
   logic       reset;
   logic       write_en;
   logic [1:0] wr_chan;
   logic [4:0] wr_data;
   logic       sync_mode;
   logic [3:0] pdm_out, pending;
   logic       frame_start;
   logic [2:0] pdm3, pend3;
   logic       fs3;

   always #5 clk = ~clk;

   pdm_multi_channel #(.WIDTH(5), .CHANNELS(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .write_en    (write_en),
      .wr_chan     (wr_chan),
      .wr_data     (wr_data),
      .sync_mode   (sync_mode),
      .pdm_out     (pdm_out),
      .pending     (pending),
      .frame_start (frame_start)
   );

   pdm_multi_channel #(.WIDTH(5), .CHANNELS(3)) dut3 (
      .clk         (clk),
      .reset       (reset),
      .write_en    (write_en),
      .wr_chan     (wr_chan),
      .wr_data     (wr_data),
      .sync_mode   (sync_mode),
      .pdm_out     (pdm3),
      .pending     (pend3),
      .frame_start (fs3)
   );

   typedef struct {
      logic [3:0] pdm;
      logic [3:0] pend;
      logic       fs;
      logic [2:0] pdm3;
      logic [2:0] pend3;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model state: index 0 is the 4-channel instance, index 1 the 3-channel one.
   int   ml [2][4];
   int   ma [2][4];
   int   ms [2][4];
   bit   mp [2][4];
   bit   mo [2][4];
   int   mcnt;
   int   nch [2] = '{4, 3};
   int   ones [4];
   int   ones3 [3];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      bit bnd;
      int s;
      if (reset) begin
         mcnt = 0;
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) begin
               ml[d][c] = 0; ma[d][c] = 0; ms[d][c] = 0; mp[d][c] = 0; mo[d][c] = 0;
            end
      end else begin
         bnd = (mcnt == 31);
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < nch[d]; c++) begin
               s        = ma[d][c] + ml[d][c];
               mo[d][c] = (s >= 32);
               ma[d][c] = s % 32;
               if (bnd && mp[d][c]) begin
                  ml[d][c] = ms[d][c];
                  mp[d][c] = 0;
               end
               if (write_en && (int'(wr_chan) == c)) begin
                  if (!sync_mode || bnd) begin
                     ml[d][c] = int'(wr_data);
                     mp[d][c] = 0;
                  end else begin
                     ms[d][c] = int'(wr_data);
                     mp[d][c] = 1;
                  end
               end
            end
         mcnt = (mcnt + 1) % 32;
      end
   endtask

   task automatic push_expected();
      exp_t e;
      for (int c = 0; c < 4; c++) begin
         e.pdm[c]  = mo[0][c];
         e.pend[c] = mp[0][c];
      end
      for (int c = 0; c < 3; c++) begin
         e.pdm3[c]  = mo[1][c];
         e.pend3[c] = mp[1][c];
      end
      e.fs = (mcnt == 0);
      sb.push_back(e);
   endtask

   // One clock: model follows the edge, DUT outputs are compared at the following negedge.
   task automatic step();
      exp_t e;
      @(posedge clk);
      model_update();
      push_expected();
      @(negedge clk);
      if (sb.size() == 0) begin
         check_val("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check_val("pdm_out", 32'(pdm_out), 32'(e.pdm));
         check_val("pending", 32'(pending), 32'(e.pend));
         check_val("frame_start", 32'(frame_start), 32'(e.fs));
         check_val("pdm3", 32'(pdm3), 32'(e.pdm3));
         check_val("pend3", 32'(pend3), 32'(e.pend3));
         check_val("fs3", 32'(fs3), 32'(e.fs));
      end
      for (int c = 0; c < 4; c++) ones[c] += int'(pdm_out[c]);
      for (int c = 0; c < 3; c++) ones3[c] += int'(pdm3[c]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input int chan, input int data, input bit sync);
      write_en  = 1'b1;
      wr_chan   = 2'(chan);
      wr_data   = 5'(data);
      sync_mode = sync;
      step();
      write_en  = 1'b0;
      sync_mode = 1'b0;
   endtask

   task automatic clear_ones();
      for (int c = 0; c < 4; c++) ones[c] = 0;
      for (int c = 0; c < 3; c++) ones3[c] = 0;
   endtask

   // Advance until the next edge is taken with the given frame count (at most one frame).
   task automatic wait_cnt(input int target);
      for (int i = 0; i < 32 && mcnt != target; i++) step();
      check_val("wait_cnt", 32'(mcnt), 32'(target));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lv [3] = '{26, 31, 0};
      reset = 1'b1; write_en = 1'b0; wr_chan = '0; wr_data = '0; sync_mode = 1'b0;
      idle(2);
      check_val("rst_fs", 32'(frame_start), 32'd1);
      check_val("rst_pdm", 32'(pdm_out), 32'd0);
      reset = 1'b0;

      // Immediate write ch0 = 8.
      wr(0, 8, 1'b0);
      clear_ones();
      idle(32);
      check_val("t1_ones0", 32'(ones[0]), 32'd8);
      check_val("t1_ones_other", 32'(ones[1] + ones[2] + ones[3]), 32'd0);

      // Immediate level changes on ch0.
      for (int i = 0; i < 3; i++) begin
         wr(0, lv[i], 1'b0);
         clear_ones();
         idle(32);
         check_val("t2_ones0", 32'(ones[0]), 32'(lv[i]));
      end

      // Deferred write ch1 = 16 at frame count 10.
      wait_cnt(10);
      wr(1, 16, 1'b1);
      check_val("t3_pend_set", 32'(pending[1]), 32'd1);
      wait_cnt(31);
      check_val("t3_pend_hold", 32'(pending[1]), 32'd1);
      check_val("t3_ch1_quiet", 32'(pdm_out[1]), 32'd0);
      step();
      check_val("t3_pend_clr", 32'(pending[1]), 32'd0);
      clear_ones();
      idle(32);
      check_val("t3_ones1", 32'(ones[1]), 32'd16);

      // Pending shadow on ch3 plus a boundary-edge sync write to ch2.
      wait_cnt(3);
      wr(3, 12, 1'b1);
      wait_cnt(31);
      wr(2, 4, 1'b1);
      check_val("t4_pend32", 32'(pending[3:2]), 32'd0);
      clear_ones();
      idle(32);
      check_val("t4_ones2", 32'(ones[2]), 32'd4);
      check_val("t4_ones3", 32'(ones[3]), 32'd12);

      // Mid-frame reset with everything running and a shadow pending.
      wr(0, 20, 1'b0);
      wr(1, 7, 1'b1);
      idle(5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_val("t5_pdm", 32'(pdm_out), 32'd0);
      check_val("t5_pend", 32'(pending), 32'd0);
      check_val("t5_fs", 32'(frame_start), 32'd1);
      clear_ones();
      idle(40);
      check_val("t5_ones", 32'(ones[0] + ones[1] + ones[2] + ones[3]), 32'd0);

      // Channel 3 is out of range for the 3-channel instance.
      wr(3, 16, 1'b0);
      wr(3, 16, 1'b1);
      check_val("t6_pend3", 32'(pend3), 32'd0);
      clear_ones();
      idle(40);
      check_val("t6_ones3", 32'(ones3[0] + ones3[1] + ones3[2]), 32'd0);
      check_val("t6_ones_dut4_ch3", 32'(ones[3]), 32'd20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
